ex_muldiv_sequencer: RTL and testbench
======================================

# ex_muldiv_sequencer

Multi-cycle controller for the unsigned multiply/divide extension of the execute stage. It accepts one operation from the ID/EX boundary and runs a radix-2 iterative shift-add multiply or restoring divide over 32 cycles. While the operation runs it holds the pipeline with a stall request, then presents a one-cycle result for the EX/MEM register to capture. It sits beside the EX ALU and takes operands after hazard forwarding, the same values the ALU sees.

## Interface
- `XLEN`, 32 — operand and result width; the iteration count equals `XLEN`.
- `OP_MUL`, 2'd0 — low `XLEN` bits of op1*op2.
- `OP_MULHU`, 2'd1 — high `XLEN` bits of the unsigned product.
- `OP_DIVU`, 2'd2 — unsigned quotient.
- `OP_REMU`, 2'd3 — unsigned remainder.

Ports:
- `clk` in 1 — single clock; all state updates on its rising edge.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `ID_EX_muldiv_start` in 1 — the instruction in EX is a mul/div op.
- `ID_EX_muldiv_op` in 2 — operation select.
- `EX_op1_data` in XLEN — forwarded rs1 value.
- `EX_op2_data` in XLEN — forwarded rs2 value.
- `ID_EX_rd` in 5 — destination register.
- `EX_flush` in 1 — kill the in-flight operation.
- `EX_muldiv_stall` out 1 — hold PC, IF/ID and ID/EX.
- `EX_muldiv_busy` out 1 — state is not IDLE.
- `EX_muldiv_valid` out 1 — result valid, one-cycle pulse.
- `EX_muldiv_result` out XLEN — result; zero when not valid.
- `EX_muldiv_rd` out 5 — latched rd, qualified by valid.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE: when `start` is sampled, latch op, rd and operands, and load counter = XLEN-1.
    - Divisor == 0 with op DIVU/REMU: go to DONE.
    - Otherwise: go to CALC.
  - CALC: perform one iteration per cycle.
    - Counter == 0: go to DONE.
    - Otherwise: decrement the counter.
  - DONE: assert `valid` for one cycle, then go to IDLE unconditionally.
- Multiply datapath:
  - Registers: 2*XLEN product register and XLEN multiplicand register.
  - Each iteration: if product[0], add the multiplicand into product[2XLEN-1:XLEN] with carry. Then shift the {carry, product} value right by 1.
  - MUL returns product[XLEN-1:0]. MULHU returns product[2XLEN-1:XLEN].
- Divide datapath (restoring):
  - Registers: XLEN+1 bit remainder, XLEN quotient (initialised to the dividend), XLEN divisor.
  - Each iteration: shift {rem, quo} left by 1 and trial-subtract the divisor. If the result is non-negative, keep it and set quo[0]=1. Otherwise restore.
  - DIVU returns the quotient. REMU returns rem[XLEN-1:0].
- Divide by zero follows RISC-V: DIVU → 32'hFFFF_FFFF; REMU → op1 unchanged.
- `EX_muldiv_stall` = (IDLE && start && !flush) || CALC. It is combinational and low in DONE, so the held instruction advances on the DONE edge.
- `start` is ignored in CALC and DONE.
- Flush:
  - `EX_flush` in any state forces the next state to IDLE.
  - A flush in DONE suppresses `valid` in that same cycle.
  - A `start` coinciding with `flush` in IDLE is not accepted.
- Async reset:
  - State → IDLE; counter, datapath registers and latched rd → 0.
  - All outputs → 0.
  - Reset mid-CALC aborts with no valid pulse.

## Timing
- `start` sampled at edge E0 → CALC occupies the following 32 cycles → DONE in the 33rd cycle after E0. `valid` is high for exactly one cycle, and stall is high for 33 cycles including the start cycle.
- Divide by zero: DONE in the cycle after E0; stall high for one cycle.
- Back-to-back operations: the next start can be sampled in the IDLE cycle after DONE at the earliest. This gives a minimum spacing of 34 cycles start-to-start.
- Operands are sampled only at the accepting edge. Later changes on `EX_op*_data` have no effect.
- `result` and `rd` are registered, stable throughout DONE, and 0 outside DONE.

## Test plan
- MUL 7 × 6 (start at cycle 0):
  - stall high cycles 0–32.
  - valid at cycle 33 with result 42 and rd echoed.
  - Then returns to IDLE.
- MULHU 32'hFFFF_FFFF × 32'hFFFF_FFFF:
  - result 32'hFFFF_FFFE.
  - MUL of the same operands gives 32'h0000_0001.
- DIVU 100 / 7 gives 14; REMU 100 / 7 gives 2. DIVU 5 / 9 gives 0; REMU 5 / 9 gives 5.
- Divide by zero:
  - DIVU 123 / 0 gives 32'hFFFF_FFFF with valid on the cycle after start; REMU 123 / 0 gives 123.
  - Stall lasts exactly one cycle.
- Flush:
  - Flush at CALC cycle 10 → IDLE the next cycle, no valid pulse, stall drops.
  - `start` together with `flush` in IDLE → not accepted, busy stays 0.
- Reset:
  - Assert `rst_n` low asynchronously mid-CALC → all outputs 0 immediately.
  - After release, a new MUL 3 × 3 completes with result 9 at the nominal latency.
  - A `start` pulse during CALC is ignored; the original result is unchanged.

Source files
------------

// File: rtl/ex_muldiv_sequencer.sv
// Unsigned multiply/divide sequencer for the execute stage (radix-2 shift-add MUL, restoring DIV).
// Latency: 33 cycles start-to-valid (XLEN iterations + DONE); 1 cycle for divide-by-zero.
// Backpressure: stalls PC/IF/ID/ID-EX from the accept cycle through CALC; flush aborts to IDLE.
module ex_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ID_EX_muldiv_start,
  input  logic [1:0]      ID_EX_muldiv_op,
  input  logic [XLEN-1:0] EX_op1_data,
  input  logic [XLEN-1:0] EX_op2_data,
  input  logic [4:0]      ID_EX_rd,
  input  logic            EX_flush,
  output logic            EX_muldiv_stall,
  output logic            EX_muldiv_busy,
  output logic            EX_muldiv_valid,
  output logic [XLEN-1:0] EX_muldiv_result,
  output logic [4:0]      EX_muldiv_rd
);

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULHU = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_REMU  = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int            CW       = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_div0;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvsr;

  logic              w_accept;
  logic              w_div0_in;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_sub;
  logic              w_valid;
  logic [XLEN-1:0]   w_result;

  // A start is taken only from IDLE and only if the same cycle is not being flushed.
  assign w_accept  = (r_state == S_IDLE) && ID_EX_muldiv_start && !EX_flush;
  assign w_div0_in = ID_EX_muldiv_op[1] && (EX_op2_data == '0);

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_div0_in ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (EX_flush) w_state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // One shift-add step: add multiplicand into the high half when product[0] is set, keep the carry.
  assign w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);

  // One restoring step: the remainder is always below the divisor, so the
  // shifted value fits XLEN+1 bits and the trial-subtract sign is its top bit.
  // After restore/keep the top bit is zero again, so only XLEN bits are stored.
  assign w_div_shift = {r_rem, r_quo[XLEN-1]};
  assign w_div_sub   = w_div_shift - {1'b0, r_dvsr};

  // Operand capture on accept, then one multiply and one divide iteration per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_div0  <= 1'b0;
      r_prod  <= '0;
      r_mcand <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
    end else if (w_accept) begin
      r_cnt   <= CNT_LAST;
      r_op    <= ID_EX_muldiv_op;
      r_rd    <= ID_EX_rd;
      r_div0  <= w_div0_in;
      r_prod  <= {{XLEN{1'b0}}, EX_op2_data};
      r_mcand <= EX_op1_data;
      r_rem   <= '0;
      r_quo   <= EX_op1_data;
      r_dvsr  <= EX_op2_data;
    end else if (r_state == S_CALC) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
      if (!w_div_sub[XLEN]) begin
        r_rem <= w_div_sub[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= w_div_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
    end
  end

  // Result select; a zero divisor skips CALC so the quotient register still holds the dividend.
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_MUL:   w_result = r_prod[XLEN-1:0];
      OP_MULHU: w_result = r_prod[2*XLEN-1:XLEN];
      OP_DIVU:  w_result = r_div0 ? {XLEN{1'b1}} : r_quo;
      OP_REMU:  w_result = r_div0 ? r_quo : r_rem;
      default:  w_result = '0;
    endcase
  end

  assign w_valid          = (r_state == S_DONE) && !EX_flush;
  assign EX_muldiv_valid  = w_valid;
  assign EX_muldiv_result = w_valid ? w_result : '0;
  assign EX_muldiv_rd     = w_valid ? r_rd : '0;
  assign EX_muldiv_busy   = (r_state != S_IDLE);
  // Stall is held low during reset even if start is asserted in the same cycle.
  assign EX_muldiv_stall  = rst_n && (w_accept || (r_state == S_CALC));

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
module tb_ex_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op1, op2;
  logic [4:0]  rd;
  logic        flush;
  logic        stall, busy, valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_muldiv_sequencer #(.XLEN(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ID_EX_muldiv_start (start),
    .ID_EX_muldiv_op    (op),
    .EX_op1_data        (op1),
    .EX_op2_data        (op2),
    .ID_EX_rd           (rd),
    .EX_flush           (flush),
    .EX_muldiv_stall    (stall),
    .EX_muldiv_busy     (busy),
    .EX_muldiv_valid    (valid),
    .EX_muldiv_result   (result),
    .EX_muldiv_rd       (rd_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result of an unsigned RISC-V M-extension op.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op in cycle 0 (caller is #1 after a rising edge), observe 40 cycles.
  // flush_cyc < 0: no flush; otherwise flush is driven high for that one cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input int flush_cyc, input bit poke);
    logic [31:0] exp_res, v_res;
    logic [4:0]  v_rd;
    int exp_lat, exp_stall, after_cyc;
    int v_cnt, v_cyc, s_cnt, leak;
    bit killed, poke_ok;
    logic v_stall, busy1, busy_after;
    exp_res  = model(o, a, b);
    exp_lat  = (o[1] && b == 0) ? 1 : 33;
    killed   = (flush_cyc >= 0) && (flush_cyc <= exp_lat);
    poke_ok  = poke && exp_lat == 33 && (flush_cyc < 0 || flush_cyc > 6);
    if (!killed)             exp_stall = exp_lat;
    else if (flush_cyc == 0) exp_stall = 0;
    else if (flush_cyc >= exp_lat) exp_stall = exp_lat;
    else                     exp_stall = flush_cyc + 1;
    after_cyc = killed ? flush_cyc + 1 : exp_lat + 1;
    v_cnt = 0; v_cyc = -1; s_cnt = 0; leak = 0;
    v_res = '0; v_rd = '0; v_stall = 1'b0; busy1 = 1'b0; busy_after = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 0) begin
        start = 1'b1; op = o; op1 = a; op2 = b; rd = d;
      end else begin
        start = poke_ok && (cyc == 5);
        op  = 2'($urandom);
        op1 = $urandom;
        op2 = $urandom;
        rd  = 5'($urandom);
      end
      flush = (cyc == flush_cyc);
      @(negedge clk);
      if (valid) begin
        v_cnt++;
        if (v_cyc < 0) begin
          v_cyc = cyc; v_res = result; v_rd = rd_out; v_stall = stall;
        end
      end else if (result != 0 || rd_out != 0) leak++;
      if (stall) s_cnt++;
      if (cyc == 1) busy1 = busy;
      if (cyc == after_cyc) busy_after = busy;
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0;
    chk("valid_cnt", v_cnt, killed ? 0 : 1);
    if (!killed) begin
      chk("latency", v_cyc, exp_lat);
      chk("result", v_res, exp_res);
      chk("rd", {27'd0, v_rd}, {27'd0, d});
      chk("stall_in_done", {31'd0, v_stall}, 32'd0);
    end
    chk("stall_cycles", s_cnt, exp_stall);
    chk("busy_cyc1", {31'd0, busy1}, (killed && flush_cyc == 0) ? 32'd0 : 32'd1);
    chk("busy_after", {31'd0, busy_after}, 32'd0);
    chk("leak", leak, 0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int bad;
    rst_n = 1'b0; start = 1'b0; op = '0; op1 = '0; op2 = '0; rd = '0; flush = 1'b0;
    #1;
    chk("reset_outs", {stall, busy, valid, |result, |rd_out}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(2'd0, 32'd7, 32'd6, 5'd11, -1, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, -1, 1'b0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, -1, 1'b0);
    run_op(2'd2, 32'd100, 32'd7, 5'd5, -1, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, 5'd6, -1, 1'b0);
    run_op(2'd2, 32'd5, 32'd9, 5'd7, -1, 1'b0);
    run_op(2'd3, 32'd5, 32'd9, 5'd8, -1, 1'b0);
    run_op(2'd2, 32'd123, 32'd0, 5'd9, -1, 1'b0);
    run_op(2'd3, 32'd123, 32'd0, 5'd10, -1, 1'b0);
    run_op(2'd0, 32'd12, 32'd13, 5'd12, 10, 1'b0);   // flush mid-CALC
    run_op(2'd2, 32'd77, 32'd5, 5'd13, 0, 1'b0);     // start together with flush
    run_op(2'd3, 32'd77, 32'd5, 5'd14, 33, 1'b0);    // flush in DONE
    run_op(2'd1, 32'h8000_0001, 32'h7FFF_FFFF, 5'd15, -1, 1'b1); // start poked during CALC

    // Asynchronous reset in the middle of CALC.
    start = 1'b1; op = 2'd0; op1 = 32'd5; op2 = 32'd5; rd = 5'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {stall, busy, valid, |result, |rd_out}, 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid || busy || stall) bad++;
    end
    chk("rst_hold_quiet", bad, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'd0, 32'd3, 32'd3, 5'd21, -1, 1'b0);

    // Randomized ops against the model.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 2));
        1:       rb = 32'($urandom_range(1, 1000));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 5'($urandom), ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 34)) : -1,
             1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
